// File: rtl/pace_ctrl.sv
// Game pacing: turns accepted frame ticks into horizon updates, speed ramp, obstacle gate and score.
// All outputs registered, one cycle after the causing input; early frame ticks are dropped, never queued.
module pace_ctrl #(
    parameter int INIT_SPEED     = 6144,
    parameter int MAX_SPEED      = 13312,
    parameter int ACCEL          = 1,
    parameter int CLEAR_FRAMES   = 180,
    parameter int MIN_UPDATE_GAP = 8,
    parameter int PX_PER_POINT   = 40960,
    parameter int MAX_SCORE      = 99999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start_key,
    input  logic        crash_in,
    output logic        update,
    output logic        start,
    output logic        crash,
    output logic        running,
    output logic [5:0]  timer,
    output logic [14:0] speed,
    output logic        has_obstacles,
    output logic [16:0] score,
    output logic        achievement
);

    localparam int GW = (MIN_UPDATE_GAP > 2) ? $clog2(MIN_UPDATE_GAP) : 1;
    localparam int FW = $clog2(CLEAR_FRAMES + 1);

    localparam logic [GW-1:0] GAP_MAX   = GW'(MIN_UPDATE_GAP - 1);
    localparam logic [FW-1:0] CLR_FRM   = FW'(CLEAR_FRAMES);
    localparam logic [14:0]   SPD_INIT  = 15'(INIT_SPEED);
    localparam logic [15:0]   SPD_MAX   = 16'(MAX_SPEED);
    localparam logic [15:0]   SPD_STEP  = 16'(ACCEL);
    localparam logic [16:0]   PX_PT     = 17'(PX_PER_POINT);
    localparam logic [16:0]   SCORE_MAX = 17'(MAX_SCORE);

    typedef enum logic [1:0] {IDLE, RUNNING, CRASHED} state_t;

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic [FW-1:0] frame_cnt;
    logic [16:0]   px_acc;
    logic [6:0]    mod100;

    logic [16:0] acc_sum;
    logic [15:0] spd_inc;
    logic [14:0] speed_nxt;
    logic        accept;

    // Accumulator adds the pre-increment speed; the sum stays below 2^17.
    assign acc_sum   = px_acc + {2'b00, speed};
    assign spd_inc   = {1'b0, speed} + SPD_STEP;
    assign speed_nxt = (spd_inc >= SPD_MAX) ? SPD_MAX[14:0] : spd_inc[14:0];
    assign accept    = frame_tick && !crash_in && (gap_cnt == GAP_MAX);
    assign running   = (state == RUNNING);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            frame_cnt     <= '0;
            px_acc        <= '0;
            mod100        <= '0;
            update        <= 1'b0;
            start         <= 1'b0;
            crash         <= 1'b0;
            achievement   <= 1'b0;
            timer         <= '0;
            speed         <= SPD_INIT;
            has_obstacles <= 1'b0;
            score         <= '0;
        end else begin
            update      <= 1'b0;
            start       <= 1'b0;
            crash       <= 1'b0;
            achievement <= 1'b0;
            if (gap_cnt != GAP_MAX)
                gap_cnt <= gap_cnt + 1'b1;
            // Frame counter reaches the limit with the update; the gate follows a cycle later.
            if (frame_cnt == CLR_FRM)
                has_obstacles <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_key) begin
                        state   <= RUNNING;
                        start   <= 1'b1;
                        gap_cnt <= GAP_MAX;
                    end
                end
                RUNNING: begin
                    if (crash_in) begin
                        state <= CRASHED;
                        crash <= 1'b1;
                    end else if (accept) begin
                        update  <= 1'b1;
                        gap_cnt <= '0;
                        timer   <= timer + 1'b1;
                        speed   <= speed_nxt;
                        if (frame_cnt != CLR_FRM)
                            frame_cnt <= frame_cnt + 1'b1;
                        if (acc_sum >= PX_PT) begin
                            px_acc <= acc_sum - PX_PT;
                            if (score != SCORE_MAX) begin
                                score <= score + 1'b1;
                                if (mod100 == 7'd99) begin
                                    mod100      <= '0;
                                    achievement <= 1'b1;
                                end else begin
                                    mod100 <= mod100 + 1'b1;
                                end
                            end
                        end else begin
                            px_acc <= acc_sum;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pace_ctrl.sv
// Directed bench for pace_ctrl: stimulus pushes expected pulses, a negedge monitor pops and compares.
module tb_pace_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start_key = 1'b0;
    logic        crash_in = 1'b0;
    logic        update, start, crash, running, has_obstacles, achievement;
    logic [5:0]  timer;
    logic [14:0] speed;
    logic [16:0] score;

    pace_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_key(start_key),
        .crash_in(crash_in), .update(update), .start(start), .crash(crash),
        .running(running), .timer(timer), .speed(speed),
        .has_obstacles(has_obstacles), .score(score), .achievement(achievement)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] K_START = 2'd0, K_UPDATE = 2'd1, K_CRASH = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [5:0]  timer;
        logic [14:0] speed;
        logic [16:0] score;
        logic        obs;
        logic        ach;
    } exp_t;

    exp_t   sbq[$];
    exp_t   mon_e;
    int     vectors = 0;
    int     miscompares = 0;
    int     ach_seen = 0;
    int     n_frames = 0;
    int     exp_score = 0;
    longint px_total = 0;

    function automatic int spd_after(int n);
        return (6144 + n > 13312) ? 13312 : 6144 + n;
    endfunction

    // Reference: score is total scaled distance divided by 40960, saturating.
    task automatic push_frame();
        exp_t e;
        int   new_score;
        px_total  += longint'(spd_after(n_frames));
        n_frames  += 1;
        new_score  = int'(px_total / 64'd40960);
        if (new_score > 99999) new_score = 99999;
        e.kind  = K_UPDATE;
        e.timer = 6'(n_frames % 64);
        e.speed = 15'(spd_after(n_frames));
        e.score = 17'(new_score);
        e.obs   = (n_frames > 180);
        e.ach   = (new_score != exp_score) && (new_score % 100 == 0);
        exp_score = new_score;
        sbq.push_back(e);
    endtask

    task automatic push_event(input logic [1:0] kind);
        exp_t e;
        e.kind  = kind;
        e.timer = 6'(n_frames % 64);
        e.speed = 15'(spd_after(n_frames));
        e.score = 17'(exp_score);
        e.obs   = (n_frames >= 180);
        e.ach   = 1'b0;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: tick is high for exactly one clock.
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic accepted_tick();
        push_frame();
        tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (start || crash || update || achievement) begin
            logic [1:0] act_kind;
            act_kind = start ? K_START : update ? K_UPDATE : crash ? K_CRASH : 2'd3;
            if (achievement) ach_seen++;
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: start=%0b crash=%0b update=%0b ach=%0b timer=%0d, none expected",
                         start, crash, update, achievement, timer);
            end else begin
                mon_e = sbq.pop_front();
                if (!$onehot0({start, crash, update}) || act_kind != mon_e.kind ||
                    timer !== mon_e.timer || speed !== mon_e.speed || score !== mon_e.score ||
                    has_obstacles !== mon_e.obs || achievement !== mon_e.ach) begin
                    miscompares++;
                    $display("FAIL pulse_%0d: got s/c/u=%0b%0b%0b timer=%0d speed=%0d score=%0d obs=%0b ach=%0b; expected kind=%0d timer=%0d speed=%0d score=%0d obs=%0b ach=%0b",
                             n_frames, start, crash, update, timer, speed, score, has_obstacles, achievement,
                             mon_e.kind, mon_e.timer, mon_e.speed, mon_e.score, mon_e.obs, mon_e.ach);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle(3);
        check("rst_update", 32'(update), 0);
        check("rst_start", 32'(start), 0);
        check("rst_crash", 32'(crash), 0);
        check("rst_running", 32'(running), 0);
        check("rst_timer", 32'(timer), 0);
        check("rst_speed", 32'(speed), 6144);
        check("rst_obs", 32'(has_obstacles), 0);
        check("rst_score", 32'(score), 0);
        check("rst_ach", 32'(achievement), 0);
        rst = 1'b1;
        idle(2);

        tick();             // ignored in IDLE
        idle(3);

        push_event(K_START);
        start_key  = 1'b1;  // tick in same cycle must not update
        frame_tick = 1'b1;
        @(negedge clk);
        start_key  = 1'b0;
        frame_tick = 1'b0;
        check("start_running", 32'(running), 1);
        check("start_timer", 32'(timer), 0);
        check("start_speed", 32'(speed), 6144);
        idle(20);

        repeat (3) begin
            accepted_tick();
            idle(99);
        end
        check("f3_timer", 32'(timer), 3);
        check("f3_speed", 32'(speed), 6147);
        check("f3_score", 32'(score), 0);

        // Frame 4 accepted; ticks 3 and 7 cycles later dropped; tick 8 cycles later accepted.
        accepted_tick();
        idle(2);
        tick();
        idle(3);
        tick();
        accepted_tick();
        check("gap_timer", 32'(timer), 5);
        idle(7);

        while (n_frames < 179) begin
            accepted_tick();
            idle(7);
        end
        accepted_tick();
        check("f180_obs_low", 32'(has_obstacles), 0);
        check("f180_score", 32'(score), 27);
        idle(1);
        check("f180_obs_high", 32'(has_obstacles), 1);
        idle(6);

        while (n_frames < 7300) begin
            accepted_tick();
            idle(7);
        end
        check("end_speed", 32'(speed), 13312);
        check("end_timer", 32'(timer), 4);
        check("end_score", 32'(score), 1745);
        check("ach_count", 32'(ach_seen), 17);

        push_event(K_CRASH);
        crash_in   = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        crash_in   = 1'b0;
        frame_tick = 1'b0;
        check("crash_running", 32'(running), 0);
        idle(8);
        tick();
        idle(8);
        start_key = 1'b1;
        idle(2);
        start_key = 1'b0;
        tick();
        idle(3);
        check("hold_timer", 32'(timer), 4);
        check("hold_speed", 32'(speed), 13312);
        check("hold_score", 32'(score), 1745);
        check("hold_obs", 32'(has_obstacles), 1);
        check("hold_running", 32'(running), 0);
        check("sb_drained", 32'(sbq.size()), 0);

        #2;
        rst = 1'b0;
        #1;
        check("arst_timer", 32'(timer), 0);
        check("arst_speed", 32'(speed), 6144);
        check("arst_score", 32'(score), 0);
        check("arst_obs", 32'(has_obstacles), 0);
        check("arst_pulses", 32'({update, start, crash, achievement}), 0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
